// File: rtl/modinv_request_scheduler_if.sv
// Request/response and engine signal bundle for the shared modular-inverse
// scheduler; slave = scheduler, master = requesters plus engine.
interface modinv_request_scheduler_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_prime;
  logic [N*W-1:0] req_a;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_inv;
  logic           rsp_err;
  logic           busy;
  logic           eng_start;
  logic [W-1:0]   eng_prime;
  logic [W-1:0]   eng_a;
  logic           eng_done;
  logic [W-1:0]   eng_result;

  modport slave (
    input  req, req_prime, req_a,
    input  eng_done, eng_result,
    output rsp_valid, rsp_id, rsp_inv, rsp_err,
    output busy, eng_start, eng_prime, eng_a
  );

  modport master (
    output req, req_prime, req_a,
    output eng_done, eng_result,
    input  rsp_valid, rsp_id, rsp_inv, rsp_err,
    input  busy, eng_start, eng_prime, eng_a
  );
endinterface

// File: rtl/modinv_request_scheduler.sv
// Round-robin scheduler sharing one start/done modular-inverse engine
// among N requesters, with operand checks and a WAIT watchdog.
module modinv_request_scheduler #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 2
) (
  input logic clk,
  input logic rst_n,
  modinv_request_scheduler_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] dbl;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] nxt_ptr;
  logic [W-1:0]   sel_prime;
  logic [W-1:0]   sel_a;
  logic           op_ok;
  logic           expire;
  int             sum;

  // Rotate requests so bit 0 is the current priority holder.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = 0;
    dbl     = {bus.req, bus.req} >> ptr;
    for (int k = 0; k < N; k++) begin
      if (!gnt_vld && dbl[k]) begin
        gnt_vld = 1'b1;
        sum     = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        gnt_id  = IDW'(sum);
      end
    end
  end

  assign nxt_ptr   = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
  assign sel_prime = bus.req_prime[gnt_id*W +: W];
  assign sel_a     = bus.req_a[gnt_id*W +: W];
  assign op_ok     = (sel_prime >= W'(2)) && (sel_a != '0) &&
                     (sel_a < sel_prime);
  assign expire    = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (gnt_vld) state_d = op_ok ? ISSUE : RESP;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.eng_done || expire) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_inv   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.eng_prime <= '0;
      bus.eng_a     <= '0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      bus.eng_start <= (state_d == ISSUE);
      bus.rsp_valid <= (state_d == RESP);
      bus.busy      <= (state_d != IDLE);
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            bus.rsp_id <= gnt_id;
            ptr        <= nxt_ptr;
            if (op_ok) begin
              bus.eng_prime <= sel_prime;
              bus.eng_a     <= sel_a;
            end else begin
              bus.rsp_err <= 1'b1;
              bus.rsp_inv <= '0;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.eng_done) begin
            bus.rsp_inv <= bus.eng_result;
            bus.rsp_err <= 1'b0;
          end else if (expire) begin
            bus.rsp_inv <= '0;
            bus.rsp_err <= 1'b1;
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modinv_request_scheduler.sv
// Directed bench for modinv_request_scheduler: vector table plus
// hand-written fairness, timeout and reset sequences.
module tb_modinv_request_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;
  localparam int ID = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  modinv_request_scheduler_if #(.N(N), .W(W), .IDW(ID)) bus ();

  modinv_request_scheduler #(
    .N(N), .W(W), .TIMEOUT(TO), .IDW(ID)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] p;
    logic [7:0] a;
    int         dly;
    logic [7:0] ret;
    logic [7:0] inv;
    logic       err;
    int         lat;
    int         starts;
  } vec_t;

  vec_t v[10];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int cd     = 0;
  int dly    = 0;
  logic [7:0] ret = '0;
  int n_start = 0;
  int n_rsp   = 0;
  logic [7:0] st_prime, st_a;
  logic rsp_seen;
  int rsp_cyc;
  logic [1:0] rsp_id_s;
  logic [7:0] rsp_inv_s;
  logic rsp_err_s;
  int ids[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("start_rsp_excl", {31'd0, bus.eng_start & bus.rsp_valid}, 0);
    bus.eng_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.eng_done   = 1'b1;
        bus.eng_result = ret;
      end
    end
    if (bus.eng_start) begin
      n_start++;
      st_prime = bus.eng_prime;
      st_a     = bus.eng_a;
      cd       = dly;
    end
    if (bus.rsp_valid) begin
      rsp_seen  = 1'b1;
      rsp_cyc   = cyc;
      rsp_id_s  = bus.rsp_id;
      rsp_inv_s = bus.rsp_inv;
      rsp_err_s = bus.rsp_err;
      ids.push_back(int'(bus.rsp_id));
      bus.req[bus.rsp_id] = 1'b0;
      n_rsp++;
    end
  endtask

  task automatic wait_rsp(input int maxc);
    for (int i = 0; i < maxc && !rsp_seen; i++) step();
    if (!rsp_seen) begin
      checks++;
      fails++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", maxc);
    end
  endtask

  task automatic post(input int id, input logic [7:0] p, input logic [7:0] a);
    bus.req_prime[id*W +: W] = p;
    bus.req_a[id*W +: W]     = a;
    bus.req[id]              = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cd = 0;
    bus.eng_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, s0, r0;
    bus.req = '0;
    bus.req_prime = '0;
    bus.req_a = '0;
    bus.eng_done = 1'b0;
    bus.eng_result = '0;
    rsp_seen = 1'b0;

    v[0] = '{0,   8'd5,  8'd3, 6,  8'd2,   8'd2,   1'b0, 8,  1};
    v[1] = '{2,   8'd5,  8'd0, 0,  8'd0,   8'd0,   1'b1, 1,  0};
    v[2] = '{2,   8'd5,  8'd7, 0,  8'd0,   8'd0,   1'b1, 1,  0};
    v[3] = '{2,   8'd1,  8'd1, 0,  8'd0,   8'd0,   1'b1, 1,  0};
    v[4] = '{1,  8'd13, 8'd11, 3,  8'd6,   8'd6,   1'b0, 5,  1};
    v[5] = '{3, 8'd251,  8'd2, 10, 8'd126, 8'd126, 1'b0, 12, 1};
    v[6] = '{2,   8'd7,  8'd6, 1,  8'd6,   8'd6,   1'b0, 3,  1};
    v[7] = '{1,   8'd2,  8'd1, 2,  8'd1,   8'd1,   1'b0, 4,  1};
    v[8] = '{0,   8'd5,  8'd5, 0,  8'd0,   8'd0,   1'b1, 1,  0};
    v[9] = '{3,   8'd7,  8'd3, TO, 8'd5,   8'd5,   1'b0, TO + 2, 1};

    step();
    step();
    chk("reset_outs",
        {bus.rsp_valid, bus.rsp_err, bus.eng_start, bus.busy,
         bus.rsp_id, bus.rsp_inv, bus.eng_prime, bus.eng_a}, 0);
    rst_n = 1'b1;
    step();

    foreach (v[i]) begin
      dly = v[i].dly;
      ret = v[i].ret;
      rsp_seen = 1'b0;
      s0 = n_start;
      post(v[i].id, v[i].p, v[i].a);
      t0 = cyc;
      wait_rsp(200);
      chk($sformatf("v%0d_id", i), rsp_id_s, v[i].id);
      chk($sformatf("v%0d_inv", i), rsp_inv_s, v[i].inv);
      chk($sformatf("v%0d_err", i), rsp_err_s, v[i].err);
      chk($sformatf("v%0d_lat", i), rsp_cyc - t0, v[i].lat);
      chk($sformatf("v%0d_starts", i), n_start - s0, v[i].starts);
      if (v[i].starts == 1) begin
        chk($sformatf("v%0d_eprime", i), st_prime, v[i].p);
        chk($sformatf("v%0d_ea", i), st_a, v[i].a);
      end
      step();
    end

    // Fairness: all four request at once after a fresh reset.
    do_reset();
    ids.delete();
    dly = 4;
    ret = 8'd6;
    s0 = n_start;
    r0 = n_rsp;
    for (int k = 0; k < N; k++) post(k, 8'd13, 8'd11);
    for (int k = 0; k < N; k++) begin
      rsp_seen = 1'b0;
      wait_rsp(100);
      chk($sformatf("rr_inv%0d", k), rsp_inv_s, 8'd6);
    end
    chk("rr_count", n_rsp - r0, N);
    chk("rr_starts", n_start - s0, N);
    for (int k = 0; k < N; k++) begin
      if (k < ids.size()) chk($sformatf("rr_order%0d", k), ids[k], k);
    end
    step();

    // Timeout: engine never answers, then a normal request follows.
    dly = 0;
    rsp_seen = 1'b0;
    post(1, 8'd7, 8'd3);
    t0 = cyc;
    wait_rsp(200);
    chk("to_err", rsp_err_s, 1);
    chk("to_inv", rsp_inv_s, 0);
    chk("to_lat", rsp_cyc - t0, TO + 2);
    step();
    dly = 2;
    ret = 8'd5;
    rsp_seen = 1'b0;
    post(2, 8'd7, 8'd3);
    t0 = cyc;
    wait_rsp(50);
    chk("after_to_err", rsp_err_s, 0);
    chk("after_to_inv", rsp_inv_s, 8'd5);
    chk("after_to_lat", rsp_cyc - t0, 4);
    step();

    // Engine answering one cycle too late loses to the watchdog.
    dly = TO + 1;
    ret = 8'd5;
    rsp_seen = 1'b0;
    post(0, 8'd7, 8'd3);
    t0 = cyc;
    wait_rsp(200);
    chk("late_err", rsp_err_s, 1);
    chk("late_lat", rsp_cyc - t0, TO + 2);
    step();
    step();

    // Spurious eng_done while idle.
    r0 = n_rsp;
    bus.eng_result = 8'h55;
    bus.eng_done = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("spurious_done", n_rsp - r0, 0);
    chk("spurious_busy", bus.busy, 0);

    // Reset asserted while WAIT is in progress.
    dly = 20;
    ret = 8'd6;
    rsp_seen = 1'b0;
    post(3, 8'd11, 8'd2);
    for (int k = 0; k < 5; k++) step();
    chk("wait_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    cd = 0;
    #1;
    chk("async_rst_outs",
        {bus.rsp_valid, bus.rsp_err, bus.eng_start, bus.busy,
         bus.rsp_id, bus.rsp_inv, bus.eng_prime, bus.eng_a}, 0);
    r0 = n_rsp;
    step();
    step();
    rst_n = 1'b1;
    rsp_seen = 1'b0;
    t0 = cyc;
    wait_rsp(100);
    chk("rst_resv_id", rsp_id_s, 3);
    chk("rst_resv_inv", rsp_inv_s, 8'd6);
    chk("rst_resv_err", rsp_err_s, 0);
    chk("rst_resv_lat", rsp_cyc - t0, 22);
    chk("rst_resv_count", n_rsp - r0, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
